// File: rtl/selfcheck_sequencer_if.sv
// rtl/selfcheck_sequencer_if.sv - harness/sequencer signal bundle
// master is the test harness side, slave is the sequencer side.
interface selfcheck_sequencer_if;
  logic        start;
  logic        hold;
  logic [63:0] result;
  logic [31:0] stim;
  logic [63:0] crc;
  logic [63:0] sum;
  logic [31:0] cyc;
  logic        busy;
  logic        done;
  logic        pass;
  logic        fail;

  modport master (
    output start, hold, result,
    input  stim, crc, sum, cyc, busy, done, pass, fail
  );

  modport slave (
    input  start, hold, result,
    output stim, crc, sum, cyc, busy, done, pass, fail
  );
endinterface

// File: rtl/selfcheck_sequencer.sv
// rtl/selfcheck_sequencer.sv - LFSR stimulus generator and signature checker
// Drives stim from an LFSR, folds the DUT result into a signature, checks both at LAST_CYC.
module selfcheck_sequencer #(
  parameter logic [63:0] SEED       = 64'h5aef0c8d_d70a4497,
  parameter int unsigned WARMUP_CYC = 10,
  parameter int unsigned LAST_CYC   = 99,
  parameter logic [63:0] EXP_CRC    = 64'hc77bb9b3784ea091,
  parameter logic [63:0] EXP_SUM    = 64'h4afe43fb79d7b71e
) (
  input logic                  clk,
  input logic                  reset,
  selfcheck_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    WARMUP = 3'd2,
    RUN    = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t      state, state_nx;
  logic [63:0] crc_q, crc_nx;
  logic [63:0] sum_q, sum_nx;
  logic [31:0] cyc_q, cyc_nx;
  logic        pass_q, pass_nx;
  logic        fail_q, fail_nx;
  logic        match;

  function automatic logic [63:0] lfsr_step(input logic [63:0] x);
    return {x[62:0], x[63] ^ x[2] ^ x[0]};
  endfunction

  assign match = (crc_q == EXP_CRC) && (sum_q == EXP_SUM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      crc_q  <= '0;
      sum_q  <= '0;
      cyc_q  <= '0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      state  <= state_nx;
      crc_q  <= crc_nx;
      sum_q  <= sum_nx;
      cyc_q  <= cyc_nx;
      pass_q <= pass_nx;
      fail_q <= fail_nx;
    end
  end

  always_comb begin
    state_nx = state;
    crc_nx   = crc_q;
    sum_nx   = sum_q;
    cyc_nx   = cyc_q;
    pass_nx  = pass_q;
    fail_nx  = fail_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = SETUP;
          cyc_nx   = '0;
        end
      end
      SETUP: begin
        if (!bus.hold) begin
          crc_nx   = SEED;
          sum_nx   = '0;
          cyc_nx   = 32'd1;
          state_nx = (WARMUP_CYC == 32'd1) ? RUN : WARMUP;
        end
      end
      WARMUP: begin
        if (!bus.hold) begin
          crc_nx = lfsr_step(crc_q);
          sum_nx = '0;
          cyc_nx = cyc_q + 32'd1;
          if (cyc_q + 32'd1 == WARMUP_CYC) state_nx = RUN;
        end
      end
      RUN: begin
        if (!bus.hold) begin
          crc_nx = lfsr_step(crc_q);
          sum_nx = bus.result ^ lfsr_step(sum_q);
          cyc_nx = cyc_q + 32'd1;
          if (cyc_q + 32'd1 == LAST_CYC) state_nx = CHECK;
        end
      end
      CHECK: begin
        // Compares the pre-edge values; crc and sum stay frozen from here on.
        pass_nx  = match;
        fail_nx  = !match;
        state_nx = DONE;
      end
      DONE: begin
        if (bus.start) begin
          state_nx = SETUP;
          cyc_nx   = '0;
          pass_nx  = 1'b0;
          fail_nx  = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.stim = crc_q[31:0];
  assign bus.crc  = crc_q;
  assign bus.sum  = sum_q;
  assign bus.cyc  = cyc_q;
  assign bus.busy = (state == SETUP) || (state == WARMUP) || (state == RUN) || (state == CHECK);
  assign bus.done = (state == DONE);
  assign bus.pass = pass_q;
  assign bus.fail = fail_q;

endmodule
